// File: rtl/pe_load_sequencer.sv
// Host-side load/compute sequencer for one processing element: streams a weight and an
// activation vector into the PE, issues one start per output position and buffers results.
module pe_load_sequencer #(
  parameter int DATA_WIDTH      = 16,
  parameter int KERNEL_SIZE     = 3,
  parameter int ACTIVATION_SIZE = 5,
  parameter int TIMEOUT         = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  host_we,
  input  logic                  host_sel,
  input  logic [7:0]            host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  input  logic                  go,
  input  logic [7:0]            res_addr,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  load_enable_weight,
  output logic                  load_enable_activation,
  output logic [DATA_WIDTH-1:0] filter_input,
  output logic [DATA_WIDTH-1:0] activation_input,
  output logic                  start,
  input  logic [DATA_WIDTH-1:0] processingelement_out,
  input  logic                  compute_done,
  input  logic                  load_done,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int NUM_OUT = ACTIVATION_SIZE - KERNEL_SIZE + 1;
  localparam int IW      = $clog2(ACTIVATION_SIZE + 1);
  localparam int OW      = $clog2(NUM_OUT + 1);
  localparam int TW      = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_W, S_WAIT_WLD, S_LOAD_A, S_WAIT_ALD,
    S_WAIT_CD, S_GAP, S_DONE, S_ERROR
  } state_t;

  state_t                state, state_n;
  logic [IW-1:0]         idx, idx_n;
  logic [OW-1:0]         iter, iter_n;
  logic [TW-1:0]         timer;
  logic                  capture;
  logic                  timeout_hit;
  logic                  waiting;
  logic                  wr_w, wr_a;

  logic [DATA_WIDTH-1:0] w_buf   [KERNEL_SIZE];
  logic [DATA_WIDTH-1:0] a_buf   [ACTIVATION_SIZE];
  logic [DATA_WIDTH-1:0] res_buf [NUM_OUT];

  logic                  lew_n, lea_n, start_n, busy_n, done_n, error_n;
  logic [DATA_WIDTH-1:0] filter_n, act_n;

  assign wr_w        = host_we && !busy && !host_sel;
  assign wr_a        = host_we && !busy &&  host_sel;
  assign waiting     = (state == S_WAIT_WLD) || (state == S_WAIT_ALD) || (state == S_WAIT_CD);
  // Deciding one cycle early makes error rise exactly TIMEOUT cycles after wait entry.
  assign timeout_hit = (timer == TW'(TIMEOUT - 1));

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    iter_n  = iter;
    capture = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (go) begin
          state_n = S_LOAD_W;
          idx_n   = '0;
        end
      end
      S_LOAD_W: begin
        if (idx == IW'(KERNEL_SIZE - 1)) begin
          state_n = S_WAIT_WLD;
          idx_n   = '0;
        end else begin
          idx_n = idx + 1'b1;
        end
      end
      S_WAIT_WLD: begin
        if (load_done)        state_n = S_LOAD_A;
        else if (timeout_hit) state_n = S_ERROR;
      end
      S_LOAD_A: begin
        if (idx == IW'(ACTIVATION_SIZE - 1)) begin
          state_n = S_WAIT_ALD;
          idx_n   = '0;
        end else begin
          idx_n = idx + 1'b1;
        end
      end
      S_WAIT_ALD: begin
        if (load_done) begin
          state_n = S_WAIT_CD;
          iter_n  = '0;
        end else if (timeout_hit) begin
          state_n = S_ERROR;
        end
      end
      S_WAIT_CD: begin
        if (compute_done) begin
          capture = 1'b1;
          state_n = S_GAP;
        end else if (timeout_hit) begin
          state_n = S_ERROR;
        end
      end
      S_GAP: begin
        iter_n = iter + 1'b1;
        if (iter == OW'(NUM_OUT - 1)) state_n = S_DONE;
        else                          state_n = S_WAIT_CD;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they belong to.
  always_comb begin
    lew_n    = (state_n == S_LOAD_W);
    lea_n    = (state_n == S_LOAD_A);
    start_n  = (state_n == S_WAIT_CD);
    busy_n   = !((state_n == S_IDLE) || (state_n == S_DONE) || (state_n == S_ERROR));
    done_n   = (state_n == S_DONE) && (state != S_DONE);
    error_n  = (state_n == S_ERROR);
    filter_n = '0;
    act_n    = '0;
    // A host write in the same cycle as go is forwarded so the first word is fresh.
    if (lew_n) begin
      for (int i = 0; i < KERNEL_SIZE; i++) begin
        if (idx_n == IW'(i))
          filter_n = (wr_w && host_addr == 8'(i)) ? host_wdata : w_buf[i];
      end
    end
    if (lea_n) begin
      for (int i = 0; i < ACTIVATION_SIZE; i++) begin
        if (idx_n == IW'(i))
          act_n = (wr_a && host_addr == 8'(i)) ? host_wdata : a_buf[i];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state                  <= S_IDLE;
      idx                    <= '0;
      iter                   <= '0;
      timer                  <= '0;
      load_enable_weight     <= 1'b0;
      load_enable_activation <= 1'b0;
      filter_input           <= '0;
      activation_input       <= '0;
      start                  <= 1'b0;
      busy                   <= 1'b0;
      done                   <= 1'b0;
      error                  <= 1'b0;
    end else begin
      state                  <= state_n;
      idx                    <= idx_n;
      iter                   <= iter_n;
      load_enable_weight     <= lew_n;
      load_enable_activation <= lea_n;
      filter_input           <= filter_n;
      activation_input       <= act_n;
      start                  <= start_n;
      busy                   <= busy_n;
      done                   <= done_n;
      error                  <= error_n;
      if (state_n != state) timer <= '0;
      else if (waiting)     timer <= timer + 1'b1;
    end
  end

  // NOTE: the buffers are small register arrays, so reset clears them explicitly.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < KERNEL_SIZE; i++)     w_buf[i]   <= '0;
      for (int i = 0; i < ACTIVATION_SIZE; i++) a_buf[i]   <= '0;
      for (int i = 0; i < NUM_OUT; i++)         res_buf[i] <= '0;
    end else begin
      for (int i = 0; i < KERNEL_SIZE; i++)
        if (wr_w && host_addr == 8'(i)) w_buf[i] <= host_wdata;
      for (int i = 0; i < ACTIVATION_SIZE; i++)
        if (wr_a && host_addr == 8'(i)) a_buf[i] <= host_wdata;
      for (int i = 0; i < NUM_OUT; i++)
        if (capture && iter == OW'(i)) res_buf[i] <= processingelement_out;
    end
  end

  always_comb begin
    res_data = '0;
    for (int i = 0; i < NUM_OUT; i++)
      if (res_addr == 8'(i)) res_data = res_buf[i];
  end

endmodule

// File: tb/tb_pe_load_sequencer.sv
// Directed self-checking bench for pe_load_sequencer (K=3, A=5, TIMEOUT=20) with a
// hand-stepped PE: load_done and compute_done are driven cycle by cycle from the tasks.
module tb_pe_load_sequencer;

  localparam int DW = 16;
  localparam int K  = 3;
  localparam int A  = 5;
  localparam int N  = A - K + 1;
  localparam int TO = 20;

  logic          clk = 1'b0;
  logic          reset;
  logic          host_we, host_sel, go;
  logic [7:0]    host_addr, res_addr;
  logic [DW-1:0] host_wdata, res_data;
  logic          load_enable_weight, load_enable_activation;
  logic [DW-1:0] filter_input, activation_input;
  logic          start, compute_done, load_done, busy, done, error;
  logic [DW-1:0] pe_out;

  logic [DW-1:0] exp_w [K];
  logic [DW-1:0] exp_a [A];
  logic [DW-1:0] exp_res [N];

  int n_checks = 0;
  int n_fail   = 0;

  pe_load_sequencer #(.DATA_WIDTH(DW), .KERNEL_SIZE(K), .ACTIVATION_SIZE(A), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .host_we(host_we), .host_sel(host_sel), .host_addr(host_addr), .host_wdata(host_wdata),
    .go(go), .res_addr(res_addr), .res_data(res_data),
    .load_enable_weight(load_enable_weight), .load_enable_activation(load_enable_activation),
    .filter_input(filter_input), .activation_input(activation_input), .start(start),
    .processingelement_out(pe_out), .compute_done(compute_done), .load_done(load_done),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic host_write(input logic sel, input logic [7:0] addr, input logic [DW-1:0] data);
    host_we = 1'b1; host_sel = sel; host_addr = addr; host_wdata = data;
    tick();
    host_we = 1'b0;
    if (!sel && addr < K) exp_w[addr] = data;
    if (sel && addr < A)  exp_a[addr] = data;
  endtask

  task automatic pulse_go();
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic check_results(input string tag);
    for (int i = 0; i < N; i++) begin
      res_addr = 8'(i); #1;
      n_checks++;
      if (res_data !== exp_res[i]) begin
        n_fail++; $display("FAIL %s res[%0d]: got %0d want %0d", tag, i, res_data, exp_res[i]);
      end
    end
  endtask

  // Entered at the negedge of the first LOAD_W cycle; leaves at WAIT_WLD entry.
  task automatic check_weights(input string tag);
    for (int i = 0; i < K; i++) begin
      n_checks++;
      if (load_enable_weight !== 1'b1 || filter_input !== exp_w[i]) begin
        n_fail++; $display("FAIL %s weight[%0d]: got en=%b data=%0d want en=1 data=%0d",
                           tag, i, load_enable_weight, filter_input, exp_w[i]);
      end
      tick();
    end
    n_checks++;
    if (load_enable_weight !== 1'b0 || filter_input !== '0) begin
      n_fail++; $display("FAIL %s weight end: got en=%b data=%0d want 0/0", tag, load_enable_weight, filter_input);
    end
  endtask

  // Entered in WAIT_WLD; acknowledges it and checks the activation stream; leaves at WAIT_ALD entry.
  task automatic check_acts(input string tag);
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    for (int i = 0; i < A; i++) begin
      n_checks++;
      if (load_enable_activation !== 1'b1 || activation_input !== exp_a[i] || busy !== 1'b1) begin
        n_fail++; $display("FAIL %s act[%0d]: got en=%b data=%0d busy=%b want en=1 data=%0d busy=1",
                           tag, i, load_enable_activation, activation_input, busy, exp_a[i]);
      end
      tick();
    end
    n_checks++;
    if (load_enable_activation !== 1'b0 || activation_input !== '0) begin
      n_fail++; $display("FAIL %s act end: got en=%b data=%0d want 0/0", tag, load_enable_activation, activation_input);
    end
  endtask

  // Entered in WAIT_ALD; the PE answers dly cycles after start rises.
  task automatic compute_phase(input string tag, input int dly,
                               input logic [DW-1:0] r0, input logic [DW-1:0] r1, input logic [DW-1:0] r2);
    logic [DW-1:0] r [N];
    r[0] = r0; r[1] = r1; r[2] = r2;
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    for (int k = 0; k < N; k++) begin
      n_checks++;
      if (start !== 1'b1) begin
        n_fail++; $display("FAIL %s start[%0d]: got %b want 1", tag, k, start);
      end
      repeat (dly) tick();
      compute_done = 1'b1; pe_out = r[k];
      tick();
      compute_done = 1'b0; pe_out = '0;
      exp_res[k] = r[k];
      n_checks++;
      if (start !== 1'b0) begin
        n_fail++; $display("FAIL %s gap[%0d]: got start=%b want 0", tag, k, start);
      end
      tick();
    end
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || start !== 1'b0) begin
      n_fail++; $display("FAIL %s done entry: got done=%b busy=%b start=%b want 1/0/0", tag, done, busy, start);
    end
    tick();
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL %s done pulse: got %b want 0 on second cycle", tag, done);
    end
    check_results(tag);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    n_checks++;
    if ({load_enable_weight, load_enable_activation, start, busy, done, error} !== 6'b0 ||
        filter_input !== '0 || activation_input !== '0) begin
      n_fail++; $display("FAIL reset outputs: got lew=%b lea=%b start=%b busy=%b done=%b error=%b want all 0",
                         load_enable_weight, load_enable_activation, start, busy, done, error);
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset idle busy: got %b want 0", busy);
    end
    check_results("reset");
  endtask

  task automatic test_full_run();
    for (int i = 0; i < K; i++) host_write(1'b0, 8'(i), DW'(i + 1));
    for (int i = 0; i < A; i++) host_write(1'b1, 8'(i), DW'(i + 1));
    host_write(1'b0, 8'd3, 16'd77);
    pulse_go();
    check_weights("full");
    check_acts("full");
    compute_phase("full", 2, 16'd14, 16'd20, 16'd26);
    res_addr = 8'd7; #1;
    n_checks++;
    if (res_data !== '0) begin
      n_fail++; $display("FAIL res out of range: got %0d want 0", res_data);
    end
  endtask

  // Restart from DONE; write and go during LOAD_W are ignored; PE answers with no delay.
  task automatic test_back_to_back();
    pulse_go();
    for (int i = 0; i < K; i++) begin
      n_checks++;
      if (load_enable_weight !== 1'b1 || filter_input !== exp_w[i]) begin
        n_fail++; $display("FAIL b2b weight[%0d]: got en=%b data=%0d want en=1 data=%0d",
                           i, load_enable_weight, filter_input, exp_w[i]);
      end
      if (i == 0) begin
        host_we = 1'b1; host_sel = 1'b0; host_addr = 8'd2; host_wdata = 16'd99; go = 1'b1;
      end
      tick();
      host_we = 1'b0; go = 1'b0;
    end
    n_checks++;
    if (load_enable_weight !== 1'b0) begin
      n_fail++; $display("FAIL b2b go ignored: got lew=%b want 0", load_enable_weight);
    end
    check_acts("b2b");
    compute_phase("b2b", 0, 16'd7, 16'd8, 16'd9);
  endtask

  // Same-cycle write with go is used; load_done outside a wait state is ignored.
  task automatic test_timeout();
    host_we = 1'b1; host_sel = 1'b0; host_addr = 8'd0; host_wdata = 16'd5; go = 1'b1;
    tick();
    host_we = 1'b0; go = 1'b0;
    exp_w[0] = 16'd5;
    load_done = 1'b1;
    for (int i = 0; i < K; i++) begin
      n_checks++;
      if (load_enable_weight !== 1'b1 || filter_input !== exp_w[i]) begin
        n_fail++; $display("FAIL timeout weight[%0d]: got en=%b data=%0d want en=1 data=%0d",
                           i, load_enable_weight, filter_input, exp_w[i]);
      end
      tick();
    end
    load_done = 1'b0;
    repeat (TO - 1) tick();
    n_checks++;
    if (error !== 1'b0 || busy !== 1'b1 || load_enable_activation !== 1'b0) begin
      n_fail++; $display("FAIL timeout early: got error=%b busy=%b lea=%b want 0/1/0",
                         error, busy, load_enable_activation);
    end
    tick();
    n_checks++;
    if (error !== 1'b1 || busy !== 1'b0 || start !== 1'b0 || load_enable_weight !== 1'b0) begin
      n_fail++; $display("FAIL timeout edge: got error=%b busy=%b start=%b lew=%b want 1/0/0/0",
                         error, busy, start, load_enable_weight);
    end
    tick();
    n_checks++;
    if (error !== 1'b1) begin
      n_fail++; $display("FAIL timeout hold: got error=%b want 1", error);
    end
    check_results("timeout");
  endtask

  task automatic test_reset_mid_run();
    pulse_go();
    n_checks++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL error clear: got error=%b busy=%b want 0/1", error, busy);
    end
    check_weights("rst");
    check_acts("rst");
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    n_checks++;
    if (start !== 1'b1) begin
      n_fail++; $display("FAIL rst wait_cd start: got %b want 1", start);
    end
    reset = 1'b1;
    tick();
    for (int i = 0; i < K; i++) exp_w[i] = '0;
    for (int i = 0; i < A; i++) exp_a[i] = '0;
    for (int i = 0; i < N; i++) exp_res[i] = '0;
    n_checks++;
    if (start !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rst mid-run: got start=%b busy=%b want 0/0", start, busy);
    end
    check_results("rst cleared");
    reset = 1'b0;
    tick();
    for (int i = 0; i < K; i++) host_write(1'b0, 8'(i), DW'(10 * (i + 1)));
    for (int i = 0; i < A; i++) host_write(1'b1, 8'(i), DW'(100 + i));
    pulse_go();
    check_weights("rerun");
    check_acts("rerun");
    compute_phase("rerun", 1, 16'd100, 16'd200, 16'd300);
  endtask

  initial begin
    reset = 1'b1; host_we = 1'b0; host_sel = 1'b0; host_addr = '0; host_wdata = '0;
    go = 1'b0; res_addr = '0; compute_done = 1'b0; load_done = 1'b0; pe_out = '0;
    for (int i = 0; i < K; i++) exp_w[i] = '0;
    for (int i = 0; i < A; i++) exp_a[i] = '0;
    for (int i = 0; i < N; i++) exp_res[i] = '0;
    tick();
    test_reset();
    test_full_run();
    test_back_to_back();
    test_timeout();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
